reg_bank_rw: RTL
================

Name: reg_bank_rw

Overview:
- General-purpose register bank for the multicycle CPU: 32 x 32-bit registers.
- One write port takes its destination index from the write-register select mux (rt / sp / ra / rd). Two read ports supply rs/rt operands and hold them latched in A/B output registers for the following cycles.
- Read results come back through a one-cycle request/valid handshake. Write-to-read forwarding applies within the same cycle.
- $0 always reads zero; $29 (sp) comes up at a fixed stack base after reset.

Parameters:
- SP_RESET, 227, reset value of register 29 (sp).
- SP_IDX, 29, index of the stack pointer register.
- RA_IDX, 31, index of the return-address register (no special behaviour; fixed for test reference).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- Reg_Write  input  1  write enable for the write port
- Write_Reg  input  5  destination index (output of write-register select mux)
- Write_Data  input  32  data to write
- Read_Req  input  1  request to sample both read ports
- Read_Reg1  input  5  rs index
- Read_Reg2  input  5  rt index
- Read_Data1  output  32  latched operand A
- Read_Data2  output  32  latched operand B
- Read_Valid  output  1  pulses high one cycle after an accepted Read_Req
- Sp_Value  output  32  current combinational value of register SP_IDX (for debug/stack checks)

Behaviour:
- Reset (reset==0, asynchronous):
  - All registers are 0 except reg[SP_IDX], which is SP_RESET.
  - Read_Data1/2 = 0, Read_Valid = 0.
  - Reset takes effect immediately, mid-operation included: a pending write or read is dropped.
  - First edge after reset deasserts behaves normally.
- Write, at posedge with Reg_Write==1:
  - reg[Write_Reg] <= Write_Data.
  - Write_Reg==0 is ignored; reg[0] stays 0 permanently.
  - Reg_Write==0: bank is unchanged.
- Read:
  - At posedge with Read_Req==1, Read_Data1 <= value(Read_Reg1) and Read_Data2 <= value(Read_Reg2); Read_Valid <= 1.
  - With Read_Req==0, Read_Data1/2 hold their last values and Read_Valid <= 0.
  - Latency: data and Read_Valid are visible the cycle after the request edge.
  - Back-to-back requests are accepted every cycle; Read_Valid stays high continuously.
- value(i) rules:
  - 0 if i==0.
  - Else Write_Data if Reg_Write==1 and Write_Reg==i (same-edge forwarding).
  - Else reg[i].
- Simultaneous events:
  - Write and read of the same index on the same edge: the latched operand gets the new Write_Data.
  - Write to index 0 plus read of index 0: the operand reads 0.
  - Read_Reg1==Read_Reg2: both outputs get identical values.
- Sp_Value = reg[SP_IDX]; it reflects a write to sp after the write edge, with no forwarding.
- No X propagation: every register has a defined reset value.
- Widths: indices are 5-bit unsigned, so all 32 are valid and there is no out-of-range case.

Test Plan:
- Reset check: assert reset=0 mid-cycle, release, Read_Req with Read_Reg1=29, Read_Reg2=5 -> next cycle Read_Data1=227, Read_Data2=0, Read_Valid=1; Sp_Value=227 throughout.
- Write then read: write 0xDEADBEEF to reg 31 (Write_Reg=31), next cycle Read_Req with Read_Reg1=31 -> Read_Data1=0xDEADBEEF one cycle later; Read_Valid high exactly one cycle per single request.
- Zero register: Reg_Write=1, Write_Reg=0, Write_Data=0x12345678 together with Read_Req on Read_Reg1=0 -> Read_Data1=0, and again 0 on a later read.
- Forwarding: same edge Reg_Write=1, Write_Reg=7, Write_Data=0xA5A5A5A5, Read_Req, Read_Reg1=7, Read_Reg2=7 -> both outputs 0xA5A5A5A5.
- Hold and streaming: three back-to-back requests on regs 1,2,3 (preloaded 1,2,3) -> Read_Data1 sequence 1,2,3 with Read_Valid high three cycles; then Read_Req=0 -> outputs hold 3 and Read_Valid=0.
- Reset mid-write: write sp=0x100, then reset=0 coincident with Reg_Write=1, Write_Reg=29, Write_Data=0x200 -> after release Sp_Value=227.

Source files
------------

// File: rtl/reg_bank_rw.sv
// 32 x 32-bit register bank: one write port, two latched read ports with a
// request/valid handshake and same-edge write-to-read forwarding.
module reg_bank_rw #(
    parameter logic [31:0] SP_RESET = 32'd227,
    parameter int          SP_IDX   = 29,
    parameter int          RA_IDX   = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Reg_Write,
    input  logic [4:0]  Write_Reg,
    input  logic [31:0] Write_Data,
    input  logic        Read_Req,
    input  logic [4:0]  Read_Reg1,
    input  logic [4:0]  Read_Reg2,
    output logic [31:0] Read_Data1,
    output logic [31:0] Read_Data2,
    output logic        Read_Valid,
    output logic [31:0] Sp_Value
);

    // Register 0 is hardwired, so neither special index may alias it or each other.
    if (SP_IDX <= 0 || SP_IDX > 31 || RA_IDX <= 0 || RA_IDX > 31 || RA_IDX == SP_IDX) begin : g_bad_idx
        $error("reg_bank_rw: invalid SP_IDX/RA_IDX");
    end

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] rd1_q, rd1_d;
    logic [31:0] rd2_q, rd2_d;
    logic        valid_q, valid_d;
    logic [31:0] val1, val2;
    logic        wr_en;

    assign wr_en = Reg_Write && (Write_Reg != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[Write_Reg] = Write_Data;
        end
    end

    // Operand values seen at this edge, forwarding a write landing on the same edge.
    always_comb begin
        val1 = regs_q[Read_Reg1];
        if (Read_Reg1 == 5'd0) begin
            val1 = '0;
        end else if (Reg_Write && (Write_Reg == Read_Reg1)) begin
            val1 = Write_Data;
        end

        val2 = regs_q[Read_Reg2];
        if (Read_Reg2 == 5'd0) begin
            val2 = '0;
        end else if (Reg_Write && (Write_Reg == Read_Reg2)) begin
            val2 = Write_Data;
        end
    end

    always_comb begin
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        valid_d = Read_Req;
        if (Read_Req) begin
            rd1_d = val1;
            rd2_d = val2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : 32'd0;
            end
            rd1_q   <= '0;
            rd2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            valid_q <= valid_d;
        end
    end

    assign Read_Data1 = rd1_q;
    assign Read_Data2 = rd2_q;
    assign Read_Valid = valid_q;
    assign Sp_Value   = regs_q[SP_IDX];

endmodule
